// File: rtl/router_pkg.sv
// Shared router definitions: serializer FSM states, flit flags, sizing helpers.
package router_pkg;

  // Integer ceiling division, used to size beat counts at elaboration time.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_e;

  // Flit flags as {first, last}; shared with the deserializer on the far end.
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

endpackage : router_pkg

// File: rtl/addr_data_serializer.sv
// Registered address/data merge with backpressure. Packs {pad, dst_addr, data}
// and streams it over a LINK_WIDTH link, most significant slice first, so the
// head beat always carries the destination address.
module addr_data_serializer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int LINK_WIDTH = 1034
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_arbiter_send,
  input  logic [ADDR_WIDTH-1:0] dst_addr_arbiter_send,
  input  logic                  valid_arbiter_send,
  output logic                  ready_arbiter_send,
  output logic [LINK_WIDTH-1:0] link_data,
  output logic                  link_valid,
  input  logic                  link_ready,
  output logic                  link_first,
  output logic                  link_last,
  output logic [ADDR_WIDTH-1:0] link_dst_addr
);

  localparam int TOTAL_W   = DATA_WIDTH + ADDR_WIDTH;
  localparam int NUM_BEATS = ceil_div(TOTAL_W, LINK_WIDTH);
  localparam int PACK_W    = NUM_BEATS * LINK_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  // The head beat must hold the whole address or the far end cannot route it.
  if (TOTAL_W - (NUM_BEATS - 1) * LINK_WIDTH < ADDR_WIDTH) begin : g_addr_check
    $error("addr_data_serializer: head beat cannot hold the full destination address");
  end

  ser_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [PACK_W-1:0]       pack_q;
  logic [PACK_W-1:0]       pack_in;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic                    accept;
  logic                    beat_fire;
  logic                    last_beat;

  assign last_beat          = (cnt_q == LAST_CNT);
  assign link_valid         = (state_q == S_SEND);
  assign link_first         = link_valid && (cnt_q == '0);
  assign link_last          = link_valid && last_beat;
  // Depends only on state and link_ready, never on valid_arbiter_send.
  assign ready_arbiter_send = (state_q == S_IDLE) | (link_ready & link_last);
  assign accept             = valid_arbiter_send & ready_arbiter_send;
  assign beat_fire          = link_valid & link_ready;
  // The pack register shifts up each beat, so the current beat is always on top.
  assign link_data          = pack_q[PACK_W-1 -: LINK_WIDTH];
  assign link_dst_addr      = dst_q;

  // Zero-extend {addr, data} into the beat-aligned packed word.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path infers a latch.
    pack_in                = '0;
    pack_in[TOTAL_W-1:0]   = {dst_addr_arbiter_send, data_arbiter_send};
  end

  // Next-state logic: a new accept on the last-beat edge keeps us in SEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_SEND;
      S_SEND: if (beat_fire && last_beat) state_d = accept ? S_SEND : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Beat counter, packed word and address: loaded on accept, advanced per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the wide pack register is reset so link_data reads zero out of reset.
    if (!rst_n) begin
      cnt_q  <= '0;
      pack_q <= '0;
      dst_q  <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      pack_q <= pack_in;
      dst_q  <= dst_addr_arbiter_send;
    end else if (beat_fire && !last_beat) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      pack_q <= pack_q << LINK_WIDTH;
    end
  end

endmodule : addr_data_serializer

// File: tb/tb_addr_data_serializer.sv
// Directed and randomised checks for addr_data_serializer in the default
// one-beat configuration and in a 64/10/32 three-beat configuration.
module tb_addr_data_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Default configuration: one beat per packet.
  logic [1023:0] data_a;
  logic [9:0]    addr_a;
  logic          valid_a, ready_a, lvalid_a, lready_a, lfirst_a, llast_a;
  logic [1033:0] ldata_a;
  logic [9:0]    ldst_a;

  addr_data_serializer dut_a (
    .clk(clk), .rst_n(rst_n),
    .data_arbiter_send(data_a), .dst_addr_arbiter_send(addr_a),
    .valid_arbiter_send(valid_a), .ready_arbiter_send(ready_a),
    .link_data(ldata_a), .link_valid(lvalid_a), .link_ready(lready_a),
    .link_first(lfirst_a), .link_last(llast_a), .link_dst_addr(ldst_a)
  );

  // Narrow configuration: three beats per packet.
  logic [63:0] data_b;
  logic [9:0]  addr_b;
  logic        valid_b, ready_b, lvalid_b, lready_b, lfirst_b, llast_b;
  logic [31:0] ldata_b;
  logic [9:0]  ldst_b;

  addr_data_serializer #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .LINK_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .data_arbiter_send(data_b), .dst_addr_arbiter_send(addr_b),
    .valid_arbiter_send(valid_b), .ready_arbiter_send(ready_b),
    .link_data(ldata_b), .link_valid(lvalid_b), .link_ready(lready_b),
    .link_first(lfirst_b), .link_last(llast_b), .link_dst_addr(ldst_b)
  );

  typedef struct {
    logic [63:0]      data;
    logic [9:0]       addr;
    logic [2:0][31:0] beats;  // beats[0] is the head beat
  } vec_t;

  typedef struct {
    logic [31:0] beat;
    logic [9:0]  addr;
    logic        first;
    logic        last;
  } exp_beat_t;

  vec_t      vecs[4];
  exp_beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference slicing of P = {22'b0, addr, data} into 32-bit beats.
  function automatic logic [31:0] model_beat(input logic [63:0] d, input logic [9:0] a, input int k);
    logic [95:0] p;
    p = {22'b0, a, d};
    return p[(2 - k) * 32 +: 32];
  endfunction

  // Offer one packet to dut_b with link_ready high and check all three beats.
  task automatic send_vec(input vec_t v, input string tag);
    @(negedge clk);
    valid_b = 1'b1; data_b = v.data; addr_b = v.addr; lready_b = 1'b1;
    #1;
    check({tag, "_ready_idle"}, 64'(ready_b), 64'd1);
    @(negedge clk);
    valid_b = 1'b0; data_b = 64'hDEAD_0000_BEEF_0000; addr_b = 10'h0F0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check({tag, "_valid"}, 64'(lvalid_b), 64'd1);
      check({tag, "_beat"},  64'(ldata_b), 64'(v.beats[k]));
      check({tag, "_flags"}, 64'({lfirst_b, llast_b}), 64'({k == 0, k == 2}));
      check({tag, "_dst"},   64'(ldst_b), 64'(v.addr));
      @(negedge clk);
    end
    #1;
    check({tag, "_idle_after"}, 64'(lvalid_b), 64'd0);
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r2;
    logic [2:0][31:0] b2b;
    int sent, cyc, beats_seen;
    bit acc;
    exp_beat_t e;

    vecs[0] = '{data: 64'h0123_4567_89AB_CDEF, addr: 10'h2AA,
                beats: {32'h89AB_CDEF, 32'h0123_4567, 32'h0000_02AA}};
    vecs[1] = '{data: 64'hFFFF_FFFF_0000_0000, addr: 10'h3FF,
                beats: {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_03FF}};
    vecs[2] = '{data: 64'h0000_0000_0000_0000, addr: 10'h001,
                beats: {32'h0000_0000, 32'h0000_0000, 32'h0000_0001}};
    vecs[3] = '{data: 64'hDEAD_BEEF_CAFE_F00D, addr: 10'h155,
                beats: {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0000_0155}};

    rst_n = 1'b0;
    valid_a = 1'b0; data_a = '0; addr_a = '0; lready_a = 1'b0;
    valid_b = 1'b0; data_b = '0; addr_b = '0; lready_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_link_valid", 64'({lvalid_a, lvalid_b}), 64'd0);
    check("rst_first_last", 64'({lfirst_a, llast_a, lfirst_b, llast_b}), 64'd0);
    check("rst_link_data_b", 64'(ldata_b), 64'd0);
    check("rst_link_data_a_zero", 64'(ldata_a == '0), 64'd1);
    check("rst_dst", 64'({ldst_a, ldst_b}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_after_release", 64'({ready_a, ready_b}), 64'b11);

    // Default config: all-ones data, addr 3FF, one beat per packet.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_a = 1'b1; data_a = '1; addr_a = 10'h3FF; lready_a = 1'b1;
      #1;
      check("a_ready_high", 64'(ready_a), 64'd1);
      if (i > 0) begin
        check("a_valid", 64'(lvalid_a), 64'd1);
        check("a_data_all_ones", 64'(&ldata_a), 64'd1);
        check("a_first_last", 64'({lfirst_a, llast_a}), 64'b11);
        check("a_dst", 64'(ldst_a), 64'h3FF);
      end
    end
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    #1;
    check("a_idle", 64'(lvalid_a), 64'd0);

    // Table-driven three-beat packets.
    foreach (vecs[i]) send_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall on beat 1 for five cycles while a second packet is offered.
    @(negedge clk);
    valid_b = 1'b1; data_b = vecs[0].data; addr_b = vecs[0].addr; lready_b = 1'b1;
    @(negedge clk);                       // beat 0 visible
    data_b = vecs[1].data; addr_b = vecs[1].addr;
    #1;
    check("stall_beat0", 64'(ldata_b), 64'(vecs[0].beats[0]));
    @(negedge clk);                       // beat 1 visible
    lready_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid_held", 64'(lvalid_b), 64'd1);
      check("stall_beat1_held", 64'(ldata_b), 64'(vecs[0].beats[1]));
      check("stall_flags_held", 64'({lfirst_b, llast_b}), 64'b00);
      check("stall_dst_held", 64'(ldst_b), 64'(vecs[0].addr));
      check("stall_ready_low", 64'(ready_b), 64'd0);
      @(negedge clk);
    end
    lready_b = 1'b1; valid_b = 1'b0;
    @(negedge clk);
    #1;
    check("stall_beat2", 64'(ldata_b), 64'(vecs[0].beats[2]));
    check("stall_last", 64'(llast_b), 64'd1);
    @(negedge clk);
    #1;
    check("stall_no_extra_packet", 64'(lvalid_b), 64'd0);

    // Back-to-back packets: six consecutive beats, no bubble.
    @(negedge clk);
    valid_b = 1'b1; data_b = vecs[0].data; addr_b = vecs[0].addr; lready_b = 1'b1;
    @(negedge clk);
    data_b = vecs[3].data; addr_b = vecs[3].addr;
    for (int i = 0; i < 6; i++) begin
      b2b = (i < 3) ? vecs[0].beats : vecs[3].beats;
      #1;
      check("b2b_valid", 64'(lvalid_b), 64'd1);
      check("b2b_beat", 64'(ldata_b), 64'(b2b[i % 3]));
      check("b2b_first", 64'(lfirst_b), 64'(i % 3 == 0));
      if (i == 2) check("b2b_ready_on_last", 64'(ready_b), 64'd1);
      if (i == 3) valid_b = 1'b0;
      @(negedge clk);
    end
    #1;
    check("b2b_idle_after", 64'(lvalid_b), 64'd0);

    // Reset pulsed during beat 1.
    @(negedge clk);
    valid_b = 1'b1; data_b = vecs[3].data; addr_b = vecs[3].addr; lready_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_beat1_before", 64'(ldata_b), 64'(vecs[3].beats[1]));
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid_drops", 64'(lvalid_b), 64'd0);
    check("rstmid_flags_clear", 64'({lfirst_b, llast_b}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_vec(vecs[1], "rstmid_restart");

    // Random packets with random link_ready against the slicing model.
    sent = 0; cyc = 0; beats_seen = 0; acc = 1'b0;
    exp_q.delete();
    valid_b = 1'b0;
    while ((sent < 1000 || exp_q.size() != 0 || lvalid_b) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc) valid_b = 1'b0;
      acc = 1'b0;
      lready_b = ($urandom_range(0, 3) != 0);
      if (!valid_b) begin
        r = $urandom; r2 = $urandom;
        data_b = {r, r2};
        r = $urandom;
        addr_b = r[9:0];
        if (sent < 1000 && $urandom_range(0, 2) != 0) valid_b = 1'b1;
      end
      #1;
      if (lvalid_b && lready_b) begin
        check("rand_beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rand_beat_data", 64'(ldata_b), 64'(e.beat));
          check("rand_beat_flags", 64'({lfirst_b, llast_b}), 64'({e.first, e.last}));
          check("rand_beat_dst", 64'(ldst_b), 64'(e.addr));
          beats_seen++;
          if (llast_b) begin
            check("rand_beats_per_pkt", 64'(beats_seen), 64'd3);
            beats_seen = 0;
          end
        end
      end
      if (valid_b && ready_b) begin
        for (int k = 0; k < 3; k++)
          exp_q.push_back('{beat: model_beat(data_b, addr_b, k), addr: addr_b,
                            first: (k == 0), last: (k == 2)});
        sent++;
        acc = 1'b1;
      end
    end
    check("rand_all_sent", 64'(sent), 64'd1000);
    check("rand_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_addr_data_serializer
